// File: rtl/uniboard_pkg.sv
// -----------------------------------------------------------------------------
// uniboard_pkg
// Shared definitions for the uniboard ADC path:
//   - adc_state_e : state encoding of the SPI ADC transaction engine
//   - ADC frame constants for a 12-bit MCP3201-class converter (16-bit frame,
//     12-bit data field at [12:1])
//   - frame_sample(): extracts the data field from a captured frame
// -----------------------------------------------------------------------------
package uniboard_pkg;

    // Transaction engine states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CS_SETUP = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_CS_HOLD  = 2'd3
    } adc_state_e;

    // A frame is 16 SCLK periods:
    //   [15:14] sample clocks (line undriven), [13] null bit,
    //   [12:1]  B11..B0 MSB-first, [0] first bit of the LSB-first repeat.
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_SAMPLE_W   = 12;
    localparam int ADC_DATA_MSB   = 12;
    localparam int ADC_DATA_LSB   = 1;

    // Pull the 12-bit conversion result out of a captured frame.
    function automatic logic [ADC_SAMPLE_W-1:0] frame_sample(
        input logic [ADC_FRAME_BITS-1:0] frame
    );
        return frame[ADC_DATA_MSB:ADC_DATA_LSB];
    endfunction

endpackage : uniboard_pkg

// File: rtl/adc_spi_reader.sv
// -----------------------------------------------------------------------------
// adc_spi_reader
// Runs one SPI read of a 12-bit MCP3201-class ADC per start request.
// Frame: chip select low, SCLK_DIV cycles of setup, 16 SCLK periods
// (low half then high half, SCLK_DIV cycles each), then chip select high for
// CS_HIGH_MIN cycles before the engine accepts a new start.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start_i   in   one-cycle start request; ignored unless idle
//   miso_i    in   raw ADC serial data (asynchronous to clk)
//   sclk_o    out  SPI clock to the ADC (registered)
//   cs_n_o    out  active-low chip select (registered, forced high by reset)
//   sample_o  out  12-bit conversion result, valid with done_o
//   done_o    out  one-cycle strobe, asserted the cycle after the last bit
// -----------------------------------------------------------------------------
module adc_spi_reader
    import uniboard_pkg::*;
#(
    parameter int SCLK_DIV    = 6,
    parameter int CS_HIGH_MIN = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    miso_i,
    output logic                    sclk_o,
    output logic                    cs_n_o,
    output logic [ADC_SAMPLE_W-1:0] sample_o,
    output logic                    done_o
);

    // One counter times every phase; size it for the longest one.
    localparam int CNT_MAX = (SCLK_DIV > CS_HIGH_MIN) ? SCLK_DIV : CS_HIGH_MIN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HIGH_MIN - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(ADC_FRAME_BITS - 1);

    adc_state_e                state_q,   state_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic                      phase_q,   phase_d;   // 0: SCLK low half, 1: high half
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [ADC_FRAME_BITS-1:0] shift_q,   shift_d;
    logic [ADC_SAMPLE_W-1:0]   sample_q,  sample_d;
    logic                      done_q,    done_d;
    logic                      sclk_q,    sclk_d;
    logic                      cs_n_q,    cs_n_d;
    logic                      miso_meta_q, miso_sync_q;

    // Two-flop synchronizer for the asynchronous MISO line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= miso_i;
            miso_sync_q <= miso_meta_q;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sample_d  = sample_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = ST_CS_SETUP;
                end
            end

            ST_CS_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    phase_d   = 1'b0;
                    bit_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // Last cycle of the high half: the ADC has held this
                        // bit since the previous falling edge, so it is stable
                        // through the synchronizer.
                        phase_d   = 1'b0;
                        shift_d   = {shift_q[ADC_FRAME_BITS-2:0], miso_sync_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d  = ST_CS_HOLD;
                            sample_d = frame_sample(shift_d);
                            done_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_CS_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pins are registered from the next state so they line up exactly
        // with state_q and never glitch.
        sclk_d = (state_d == ST_SHIFT) && phase_d;
        cs_n_d = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sample_q  <= '0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;   // reset deselects the ADC immediately
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sample_q  <= sample_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign sclk_o   = sclk_q;
    assign cs_n_o   = cs_n_q;
    assign sample_o = sample_q;
    assign done_o   = done_q;

endmodule : adc_spi_reader

// File: rtl/battery_monitor.sv
// -----------------------------------------------------------------------------
// battery_monitor
// Samples the battery through an external 12-bit SPI ADC once per
// SAMPLE_PERIOD clocks, sums each block of 16 samples and publishes the sum
// with a one-cycle valid strobe. battery_low follows the sum with hysteresis.
// Keep SAMPLE_PERIOD > SCLK_DIV*33 + CS_HIGH_MIN so a frame always finishes
// before the next start tick.
//
// Ports
//   clk_12MHz        in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   adc_miso         in   ADC serial data (asynchronous)
//   adc_sclk         out  SPI clock
//   adc_cs_n         out  active-low ADC chip select
//   battery_voltage  out  sum of the last 16 samples
//   voltage_valid    out  one-cycle pulse when battery_voltage updates
//   battery_low      out  level, sum below threshold (with hysteresis)
// -----------------------------------------------------------------------------
module battery_monitor
    import uniboard_pkg::*;
#(
    parameter int          SCLK_DIV      = 6,
    parameter int          SAMPLE_PERIOD = 12000,
    parameter int          CS_HIGH_MIN   = 8,
    parameter logic [15:0] LOW_THRESH    = 16'd40000,
    parameter logic [15:0] LOW_HYST      = 16'd1000
) (
    input  logic        clk_12MHz,
    input  logic        reset_n,
    input  logic        adc_miso,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic [15:0] battery_voltage,
    output logic        voltage_valid,
    output logic        battery_low
);

    localparam int               PER_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    // Release level in 17 bits so a large threshold plus hysteresis can
    // never wrap around to a small number.
    localparam logic [16:0] LOW_RELEASE = {1'b0, LOW_THRESH} + {1'b0, LOW_HYST};

    logic [PER_W-1:0]        per_q, per_d;
    logic                    start_tick;
    logic [ADC_SAMPLE_W-1:0] sample;
    logic                    sample_done;

    logic [15:0] acc_q,   acc_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] volt_q,  volt_d;
    logic        valid_q, valid_d;
    logic        low_q,   low_d;
    logic [15:0] sum_next;

    // ---------------------------------------------------------------- period
    // Free-running; the start tick is the wrap cycle, so the first tick after
    // reset comes a full period after release.
    assign start_tick = (per_q == PER_LAST);
    assign per_d      = start_tick ? '0 : per_q + PER_W'(1);

    always_ff @(posedge clk_12MHz or negedge reset_n) begin
        if (!reset_n) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    // ------------------------------------------------------------ SPI engine
    adc_spi_reader #(
        .SCLK_DIV    (SCLK_DIV),
        .CS_HIGH_MIN (CS_HIGH_MIN)
    ) u_reader (
        .clk      (clk_12MHz),
        .rst_n    (reset_n),
        .start_i  (start_tick),
        .miso_i   (adc_miso),
        .sclk_o   (adc_sclk),
        .cs_n_o   (adc_cs_n),
        .sample_o (sample),
        .done_o   (sample_done)
    );

    // ---------------------------------------------------- averaging/threshold
    // 16 x 4095 = 65520 fits in 16 bits, so the sum needs no carry.
    assign sum_next = acc_q + 16'(sample);

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        volt_d  = volt_q;
        valid_d = 1'b0;
        low_d   = low_q;

        if (sample_done) begin
            if (count_q == 4'd15) begin
                volt_d  = sum_next;
                acc_d   = '0;
                count_d = '0;
                valid_d = 1'b1;
                // Inside the hysteresis band the flag keeps its value.
                if (sum_next < LOW_THRESH) begin
                    low_d = 1'b1;
                end else if ({1'b0, sum_next} > LOW_RELEASE) begin
                    low_d = 1'b0;
                end
            end else begin
                acc_d   = sum_next;
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_12MHz or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            count_q <= '0;
            volt_q  <= '0;
            valid_q <= 1'b0;
            low_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            volt_q  <= volt_d;
            valid_q <= valid_d;
            low_q   <= low_d;
        end
    end

    assign battery_voltage = volt_q;
    assign voltage_valid   = valid_q;
    assign battery_low     = low_q;

endmodule : battery_monitor
